// File: rtl/csr_pkg.sv
// csr_pkg: CSR address map, funct3 operation encodings and mstatus bit positions
// shared by the CSR file and its users.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   typedef enum logic [2:0] {
      OP_RW  = 3'b001,
      OP_RS  = 3'b010,
      OP_RC  = 3'b011,
      OP_RWI = 3'b101,
      OP_RSI = 3'b110,
      OP_RCI = 3'b111
   } csr_op_e;

   // funct3[1:0] selects the update rule, funct3[2] selects the zimm operand
   localparam logic [1:0] FN_RW   = 2'b01;
   localparam logic [1:0] FN_RS   = 2'b10;
   localparam logic [1:0] FN_RC   = 2'b11;
   localparam int         OP_IMM  = 2;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/csr_file_if.sv
// csr_file_if: request/response channel between the instruction decoder
// (master) and the CSR file (slave).
interface csr_file_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [11:0] req_addr;
   logic [4:0]  req_rs1_sel;
   logic [31:0] req_rs1_data;
   logic [4:0]  req_rd_sel;
   logic        rsp_valid;
   logic [4:0]  rsp_rd_sel;
   logic        rsp_rd_we;
   logic [31:0] rsp_rd_data;
   logic        rsp_illegal;

   modport master (
      output req_valid, req_op, req_addr, req_rs1_sel, req_rs1_data, req_rd_sel,
      input  req_ready, rsp_valid, rsp_rd_sel, rsp_rd_we, rsp_rd_data, rsp_illegal
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_rs1_sel, req_rs1_data, req_rd_sel,
      output req_ready, rsp_valid, rsp_rd_sel, rsp_rd_we, rsp_rd_data, rsp_illegal
   );
endinterface

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit event counter with independently writable halves.
// A write to the low half replaces the increment for that cycle; a write to
// the high half still lets the low half count and carry into the new value.
module csr_counter64 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   input  logic        we_lo,
   input  logic        we_hi,
   input  logic [31:0] wdata,
   output logic [63:0] q
);

   // count, with software writes taking precedence over the increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (we_lo) begin
         q[31:0] <= wdata;
      end else if (we_hi) begin
         q <= {wdata, q[31:0]} + {63'd0, inc};
      end else begin
         q <= q + {63'd0, inc};
      end
   end

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file. Executes one atomic CSR read-modify-write
// per cycle, records trap entry / MRET and exports the trap vector, mepc and
// mstatus.MIE. Define CSR_COUNTERS_EN to implement mcycle/minstret(h).
module csr_file
   import csr_pkg::*;
#(
   parameter logic [31:0] HART_ID     = 32'd0,
   parameter logic [31:0] MISA        = 32'h4000_0100,
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   csr_file_if.slave   bus,
   input  logic        trap_valid,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_pc,
   input  logic        mret_valid,
   input  logic        instret,
   output logic [31:0] trap_vector,
   output logic [31:0] epc,
   output logic        irq_enable
);

   logic        mie, mpie;
   logic [31:0] mtvec, mscratch, mepc, mcause;
   logic [31:0] old_val, new_val, operand;
   logic        mapped, read_only, wr_attempt, illegal, accept, do_write;

`ifdef CSR_COUNTERS_EN
   logic [63:0] mcycle, minstret;

   csr_counter64 u_mcycle (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (1'b1),
      .we_lo (do_write && bus.req_addr == CSR_MCYCLE),
      .we_hi (do_write && bus.req_addr == CSR_MCYCLEH),
      .wdata (new_val),
      .q     (mcycle)
   );

   csr_counter64 u_minstret (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (instret),
      .we_lo (do_write && bus.req_addr == CSR_MINSTRET),
      .we_hi (do_write && bus.req_addr == CSR_MINSTRETH),
      .wdata (new_val),
      .q     (minstret)
   );
`else
   logic unused_instret;
   assign unused_instret = instret;
`endif

   assign bus.req_ready = !trap_valid && !mret_valid;
   assign accept        = bus.req_valid && bus.req_ready;
   assign operand       = bus.req_op[OP_IMM] ? {27'd0, bus.req_rs1_sel} : bus.req_rs1_data;
   assign wr_attempt    = (bus.req_op[1:0] == FN_RW) || (bus.req_rs1_sel != 5'd0);
   // funct3 x00 is not a CSR op; addr[11:10] = 11 marks the read-only space
   assign illegal       = !mapped || (bus.req_op[1:0] == 2'b00) ||
                          (wr_attempt && ((bus.req_addr[11:10] == 2'b11) || read_only));
   assign do_write      = accept && wr_attempt && !illegal;

   assign trap_vector = {mtvec[31:2], 2'b00};
   assign epc         = mepc;
   assign irq_enable  = mie;

   // address decode and read mux
   always_comb begin
      old_val   = '0;
      mapped    = 1'b1;
      read_only = 1'b0;
      case (bus.req_addr)
         CSR_MSTATUS: begin
            old_val[MSTATUS_MIE]  = mie;
            old_val[MSTATUS_MPIE] = mpie;
         end
         CSR_MISA: begin
            old_val   = MISA;
            read_only = 1'b1;
         end
         CSR_MTVEC:     old_val = mtvec;
         CSR_MSCRATCH:  old_val = mscratch;
         CSR_MEPC:      old_val = mepc;
         CSR_MCAUSE:    old_val = mcause;
         CSR_MHARTID: begin
            old_val   = HART_ID;
            read_only = 1'b1;
         end
`ifdef CSR_COUNTERS_EN
         CSR_MCYCLE:    old_val = mcycle[31:0];
         CSR_MCYCLEH:   old_val = mcycle[63:32];
         CSR_MINSTRET:  old_val = minstret[31:0];
         CSR_MINSTRETH: old_val = minstret[63:32];
`endif
         default:       mapped = 1'b0;
      endcase
   end

   // read-modify-write rule
   always_comb begin
      case (bus.req_op[1:0])
         FN_RS:   new_val = old_val | operand;
         FN_RC:   new_val = old_val & ~operand;
         default: new_val = operand;
      endcase
   end

   // architectural state: trap beats mret beats a software write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mie      <= 1'b0;
         mpie     <= 1'b0;
         mtvec    <= RESET_MTVEC;
         mscratch <= '0;
         mepc     <= '0;
         mcause   <= '0;
      end else if (trap_valid) begin
         mepc   <= {trap_pc[31:2], 2'b00};
         mcause <= trap_cause;
         mpie   <= mie;
         mie    <= 1'b0;
      end else if (mret_valid) begin
         mie  <= mpie;
         mpie <= 1'b1;
      end else if (do_write) begin
         case (bus.req_addr)
            CSR_MSTATUS: begin
               mie  <= new_val[MSTATUS_MIE];
               mpie <= new_val[MSTATUS_MPIE];
            end
            CSR_MTVEC:    mtvec    <= new_val;
            CSR_MSCRATCH: mscratch <= new_val;
            CSR_MEPC:     mepc     <= {new_val[31:2], 2'b00};
            CSR_MCAUSE:   mcause   <= new_val;
            default: ;
         endcase
      end
   end

   // one-cycle response carrying the pre-update value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsp_valid   <= 1'b0;
         bus.rsp_rd_sel  <= '0;
         bus.rsp_rd_we   <= 1'b0;
         bus.rsp_rd_data <= '0;
         bus.rsp_illegal <= 1'b0;
      end else begin
         bus.rsp_valid   <= accept;
         bus.rsp_rd_sel  <= bus.req_rd_sel;
         bus.rsp_rd_we   <= accept && !illegal && (bus.req_rd_sel != 5'd0);
         bus.rsp_rd_data <= illegal ? 32'd0 : old_val;
         bus.rsp_illegal <= accept && illegal;
      end
   end

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed vectors against a register-level reference model of
// the CSR file, plus literal expectations on selected responses.
module tb_csr_file;
   import csr_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        trap_valid, mret_valid, instret;
   logic [31:0] trap_cause, trap_pc;
   logic [31:0] trap_vector, epc;
   logic        irq_enable;

   csr_file_if bus ();

   csr_file dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .trap_valid  (trap_valid),
      .trap_cause  (trap_cause),
      .trap_pc     (trap_pc),
      .mret_valid  (mret_valid),
      .instret     (instret),
      .trap_vector (trap_vector),
      .epc         (epc),
      .irq_enable  (irq_enable)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // reference model state
   logic        m_mie, m_mpie;
   logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
   logic [63:0] m_cyc, m_ins;
   logic        cwl, cwh, iwl, iwh;
   logic [31:0] cnt_wd;
   logic        exp_valid, exp_we, exp_ill;
   logic [4:0]  exp_sel;
   logic [31:0] exp_data;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      nvec++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic void mreset();
      m_mie = 0; m_mpie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_cyc = 0; m_ins = 0; exp_valid = 0; exp_we = 0; exp_ill = 0; exp_sel = 0; exp_data = 0;
   endfunction

   function automatic void mread(input logic [11:0] a, output logic [31:0] v, output bit ok);
      ok = 1'b1;
      v  = 32'd0;
      case (a)
         12'h300: v = (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
         12'h301: v = 32'h4000_0100;
         12'h305: v = m_mtvec;
         12'h340: v = m_mscratch;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'hF14: v = 32'd0;
`ifdef CSR_COUNTERS_EN
         12'hB00: v = m_cyc[31:0];
         12'hB80: v = m_cyc[63:32];
         12'hB02: v = m_ins[31:0];
         12'hB82: v = m_ins[63:32];
`endif
         default: ok = 1'b0;
      endcase
   endfunction

   function automatic void mwrite(input logic [11:0] a, input logic [31:0] v);
      case (a)
         12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
         12'h305: m_mtvec = v;
         12'h340: m_mscratch = v;
         12'h341: m_mepc = v & 32'hFFFF_FFFC;
         12'h342: m_mcause = v;
         12'hB00: begin cwl = 1; cnt_wd = v; end
         12'hB80: begin cwh = 1; cnt_wd = v; end
         12'hB02: begin iwl = 1; cnt_wd = v; end
         12'hB82: begin iwh = 1; cnt_wd = v; end
         default: ;
      endcase
   endfunction

   // advance one clock; the model evaluates the inputs held across the edge
   task automatic step();
      logic [31:0] old, opnd, nv;
      bit ok, wr, ill;
      @(posedge clk);
      exp_valid = 0;
      cwl = 0; cwh = 0; iwl = 0; iwh = 0; cnt_wd = 0;
      if (rst_n) begin
         if (trap_valid) begin
            m_mepc = trap_pc & 32'hFFFF_FFFC; m_mcause = trap_cause;
            m_mpie = m_mie; m_mie = 0;
         end else if (mret_valid) begin
            m_mie = m_mpie; m_mpie = 1;
         end else if (bus.req_valid) begin
            mread(bus.req_addr, old, ok);
            wr   = (bus.req_op == 3'b001) || (bus.req_op == 3'b101) || (bus.req_rs1_sel != 0);
            ill  = !ok || (wr && (bus.req_addr[11:10] == 2'b11 || bus.req_addr == 12'h301));
            opnd = bus.req_op[2] ? 32'(bus.req_rs1_sel) : bus.req_rs1_data;
            if (bus.req_op[1:0] == 2'b10)      nv = old | opnd;
            else if (bus.req_op[1:0] == 2'b11) nv = old & ~opnd;
            else                               nv = opnd;
            exp_valid = 1;
            exp_sel   = bus.req_rd_sel;
            exp_ill   = ill;
            exp_we    = !ill && bus.req_rd_sel != 0;
            exp_data  = ill ? 32'd0 : old;
            if (!ill && wr) mwrite(bus.req_addr, nv);
         end
         if (cwl)      m_cyc = {m_cyc[63:32], cnt_wd};
         else if (cwh) m_cyc = {cnt_wd, m_cyc[31:0]} + 64'd1;
         else          m_cyc = m_cyc + 64'd1;
         if (iwl)      m_ins = {m_ins[63:32], cnt_wd};
         else if (iwh) m_ins = {cnt_wd, m_ins[31:0]} + {63'd0, instret};
         else          m_ins = m_ins + {63'd0, instret};
      end
      #1;
   endtask

   task automatic csr(input logic [2:0] op, input logic [11:0] a, input logic [4:0] sel,
                      input logic [31:0] d, input logic [4:0] rd);
      bus.req_valid = 1; bus.req_op = op; bus.req_addr = a;
      bus.req_rs1_sel = sel; bus.req_rs1_data = d; bus.req_rd_sel = rd;
      step();
      bus.req_valid = 0;
   endtask

   // continuous comparison against the model, away from the rising edge
   always @(negedge clk) begin
      chk("req_ready", 32'(bus.req_ready), 32'(!(trap_valid || mret_valid)));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
         chk("rsp_rd_sel", 32'(bus.rsp_rd_sel), 32'(exp_sel));
         chk("rsp_rd_we", 32'(bus.rsp_rd_we), 32'(exp_we));
         chk("rsp_rd_data", bus.rsp_rd_data, exp_data);
         chk("rsp_illegal", 32'(bus.rsp_illegal), 32'(exp_ill));
      end
      chk("trap_vector", trap_vector, {m_mtvec[31:2], 2'b00});
      chk("epc", epc, m_mepc);
      chk("irq_enable", 32'(irq_enable), 32'(m_mie));
   end

   initial begin
      bus.req_valid = 0; bus.req_op = 3'b001; bus.req_addr = 0;
      bus.req_rs1_sel = 0; bus.req_rs1_data = 0; bus.req_rd_sel = 0;
      trap_valid = 0; mret_valid = 0; instret = 0; trap_cause = 0; trap_pc = 0;
      mreset();
      #1 rst_n = 0;
      repeat (2) step();
      rst_n = 1;
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("reset_trap_vector", trap_vector, 0);
      chk("reset_irq", 32'(irq_enable), 0);

      // mscratch swap, back to back
      csr(OP_RW, CSR_MSCRATCH, 5'd1, 32'hDEAD_BEEF, 5'd5);
      chk("mscratch_first_old", bus.rsp_rd_data, 32'h0);
      chk("mscratch_first_we", 32'(bus.rsp_rd_we), 1);
      csr(OP_RW, CSR_MSCRATCH, 5'd1, 32'h0, 5'd5);
      chk("mscratch_second_old", bus.rsp_rd_data, 32'hDEAD_BEEF);

      // mstatus set/clear by immediate
      csr(OP_RSI, CSR_MSTATUS, 5'd8, 32'h0, 5'd1);
      chk("rsi_mie", 32'(irq_enable), 1);
      csr(OP_RCI, CSR_MSTATUS, 5'd8, 32'h0, 5'd1);
      chk("rci_old", bus.rsp_rd_data, 32'h8);
      chk("rci_mie", 32'(irq_enable), 0);

      // mtvec write and read-only set
      csr(OP_RW, CSR_MTVEC, 5'd1, 32'h8000_0103, 5'd0);
      chk("mtvec_vector", trap_vector, 32'h8000_0100);
      csr(OP_RS, CSR_MTVEC, 5'd0, 32'h0000_00FF, 5'd6);
      csr(OP_RS, CSR_MTVEC, 5'd0, 32'h0, 5'd6);
      chk("mtvec_nowrite", bus.rsp_rd_data, 32'h8000_0103);

      // read-only and unmapped accesses
      csr(OP_RW, CSR_MISA, 5'd1, 32'h1234_5678, 5'd2);
      chk("misa_wr_illegal", 32'(bus.rsp_illegal), 1);
      chk("misa_wr_we", 32'(bus.rsp_rd_we), 0);
      chk("misa_wr_data", bus.rsp_rd_data, 0);
      csr(OP_RS, CSR_MISA, 5'd0, 32'hFFFF_FFFF, 5'd2);
      chk("misa_rd", bus.rsp_rd_data, 32'h4000_0100);
      chk("misa_rd_illegal", 32'(bus.rsp_illegal), 0);
      csr(OP_RS, 12'h7C0, 5'd0, 32'h0, 5'd2);
      chk("unmapped_illegal", 32'(bus.rsp_illegal), 1);
      csr(OP_RWI, CSR_MHARTID, 5'd3, 32'h0, 5'd2);
      csr(OP_RCI, CSR_MHARTID, 5'd0, 32'h0, 5'd2);
      csr(OP_RC, CSR_MCAUSE, 5'd4, 32'h0, 5'd2);

      // mepc low bits forced to zero
      csr(OP_RW, CSR_MEPC, 5'd1, 32'h0000_0123, 5'd0);
      csr(OP_RS, CSR_MEPC, 5'd0, 32'h0, 5'd7);
      chk("mepc_align", bus.rsp_rd_data, 32'h0000_0120);

      // trap with a simultaneous request, then mret
      csr(OP_RSI, CSR_MSTATUS, 5'd8, 32'h0, 5'd0);
      bus.req_valid = 1; bus.req_op = OP_RW; bus.req_addr = CSR_MSCRATCH;
      bus.req_rs1_sel = 5'd1; bus.req_rs1_data = 32'h55; bus.req_rd_sel = 5'd1;
      trap_valid = 1; trap_cause = 32'd11; trap_pc = 32'h100;
      #1 chk("trap_req_ready", 32'(bus.req_ready), 0);
      step();
      trap_valid = 0; bus.req_valid = 0;
      chk("trap_epc", epc, 32'h100);
      chk("trap_mie", 32'(irq_enable), 0);
      chk("trap_no_rsp", 32'(bus.rsp_valid), 0);
      csr(OP_RS, CSR_MCAUSE, 5'd0, 32'h0, 5'd2);
      chk("trap_mcause", bus.rsp_rd_data, 32'd11);
      csr(OP_RS, CSR_MSTATUS, 5'd0, 32'h0, 5'd2);
      chk("trap_mstatus", bus.rsp_rd_data, 32'h80);
      csr(OP_RS, CSR_MSCRATCH, 5'd0, 32'h0, 5'd2);
      chk("trap_blocked_write", bus.rsp_rd_data, 32'h0);
      mret_valid = 1;
      step();
      mret_valid = 0;
      chk("mret_mie", 32'(irq_enable), 1);
      trap_valid = 1; mret_valid = 1; trap_cause = 32'd2; trap_pc = 32'h204;
      step();
      trap_valid = 0; mret_valid = 0;
      chk("trap_over_mret_mie", 32'(irq_enable), 0);
      chk("trap_over_mret_epc", epc, 32'h204);
      csr(OP_RS, CSR_MSTATUS, 5'd0, 32'h0, 5'd2);

`ifdef CSR_COUNTERS_EN
      // mcycle carry into a freshly written mcycleh
      csr(OP_RW, CSR_MCYCLE, 5'd1, 32'hFFFF_FFFF, 5'd0);
      csr(OP_RW, CSR_MCYCLEH, 5'd1, 32'h0, 5'd0);
      csr(OP_RS, CSR_MCYCLEH, 5'd0, 32'h0, 5'd4);
      chk("mcycleh_carry", bus.rsp_rd_data, 32'd1);
      csr(OP_RS, CSR_MCYCLE, 5'd0, 32'h0, 5'd4);
      // write beats increment on minstret
      instret = 1;
      csr(OP_RW, CSR_MINSTRET, 5'd1, 32'd5, 5'd0);
      instret = 0;
      csr(OP_RS, CSR_MINSTRET, 5'd0, 32'h0, 5'd4);
      chk("minstret_write_wins", bus.rsp_rd_data, 32'd5);
      // 64-bit wrap
      csr(OP_RW, CSR_MINSTRET, 5'd1, 32'hFFFF_FFFF, 5'd0);
      csr(OP_RW, CSR_MINSTRETH, 5'd1, 32'hFFFF_FFFF, 5'd0);
      instret = 1;
      step();
      instret = 0;
      csr(OP_RS, CSR_MINSTRET, 5'd0, 32'h0, 5'd4);
      chk("minstret_wrap_lo", bus.rsp_rd_data, 32'd0);
      csr(OP_RS, CSR_MINSTRETH, 5'd0, 32'h0, 5'd4);
      chk("minstret_wrap_hi", bus.rsp_rd_data, 32'd0);
`else
      instret = 1;
      csr(OP_RS, CSR_MCYCLE, 5'd0, 32'h0, 5'd4);
      chk("mcycle_absent", 32'(bus.rsp_illegal), 1);
      csr(OP_RW, CSR_MINSTRETH, 5'd1, 32'h5, 5'd4);
      chk("minstreth_absent", 32'(bus.rsp_illegal), 1);
      instret = 0;
`endif

      // reset while a request is being accepted
      bus.req_valid = 1; bus.req_op = OP_RW; bus.req_addr = CSR_MSCRATCH;
      bus.req_rs1_sel = 5'd1; bus.req_rs1_data = 32'h77; bus.req_rd_sel = 5'd3;
      #1 rst_n = 0;
      mreset();
      step();
      bus.req_valid = 0;
      chk("midreset_rsp_valid", 32'(bus.rsp_valid), 0);
      step();
      rst_n = 1;
      step();
      chk("postreset_rsp_valid", 32'(bus.rsp_valid), 0);
      csr(OP_RS, CSR_MSCRATCH, 5'd0, 32'h0, 5'd1);
      chk("postreset_mscratch", bus.rsp_rd_data, 32'h0);
      csr(OP_RS, CSR_MTVEC, 5'd0, 32'h0, 5'd1);
      chk("postreset_mtvec", bus.rsp_rd_data, 32'h0);
      csr(OP_RS, CSR_MSTATUS, 5'd0, 32'h0, 5'd1);
      chk("postreset_mstatus", bus.rsp_rd_data, 32'h0);
      repeat (2) step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
